uart_rx_frame: RTL and testbench

UART receive framer: turns the asynchronous `uart_rxd` serial line into bytes for the CPU's peripheral/MEM-stage UART registers. It is the receiving end of the 8N1 link whose transmit side drives `uart_txd`. It synchronises the line, finds start bits, samples each bit at mid-bit, checks the stop bit, and holds each received byte behind a valid/ack handshake. It sits between the `uart_rxd` pin and the peripheral register file. The register file reads the byte and acks it.

---
 rtl/uart_rx_frame.sv | 125 ++++++++++++
 tb/tb_uart_rx_frame.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART 8N1 receive framer: synchronises uart_rxd, samples each bit at its centre,
// checks the stop bit, and holds each byte behind a valid/ack handshake.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       uart_rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF        = CLKS_PER_BIT / 2;
  localparam logic [15:0] LP_HALF_END = 16'(HALF - 1);
  localparam logic [15:0] LP_BIT_END  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_s1;
  logic        r_rxd_s;
  logic [15:0] r_cnt;
  logic [2:0]  r_bitidx;
  logic [7:0]  r_shreg;

  logic w_half_end;
  logic w_bit_end;
  logic w_shift;
  logic w_deliver;
  logic w_ferr;
  logic w_cnt_clr;
  logic w_ack_ok;

  assign w_half_end = (r_cnt == LP_HALF_END);
  assign w_bit_end  = (r_cnt == LP_BIT_END);

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      r_s1    <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_s1    <= uart_rxd;
      r_rxd_s <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!r_rxd_s) w_state_nxt = ST_START;
      ST_START: if (w_half_end) w_state_nxt = r_rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_bit_end && (r_bitidx == 3'd7)) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_bit_end) w_state_nxt = r_rxd_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (r_rxd_s) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The counter also restarts at each data-bit sample so every bit spans C cycles.
  always_comb begin
    w_shift   = (r_state == ST_DATA) && w_bit_end;
    w_deliver = (r_state == ST_STOP) && w_bit_end && r_rxd_s;
    w_ferr    = (r_state == ST_STOP) && w_bit_end && !r_rxd_s;
    w_cnt_clr = (w_state_nxt != r_state) || w_shift;
    w_ack_ok  = rx_valid && rx_ack;
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      r_cnt     <= '0;
      r_bitidx  <= '0;
      r_shreg   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (w_cnt_clr)
        r_cnt <= '0;
      else if ((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP))
        r_cnt <= r_cnt + 16'd1;

      if ((r_state == ST_START) && (w_state_nxt == ST_DATA))
        r_bitidx <= '0;
      else if (w_shift)
        r_bitidx <= r_bitidx + 3'd1;

      if (w_shift)
        r_shreg[r_bitidx] <= r_rxd_s;

      if (w_ack_ok)
        overrun <= 1'b0;

      if (w_deliver && (!rx_valid || rx_ack)) begin
        rx_data  <= r_shreg;
        rx_valid <= 1'b1;
      end else if (w_deliver) begin
        overrun <= 1'b1;
      end else if (w_ack_ok) begin
        rx_valid <= 1'b0;
      end

      frame_err <= w_ferr;
      busy      <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at 16 clocks per bit: directed frames with a queue-based
// scoreboard checked by an independent monitor on the falling edge.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       uart_rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int t_k     = 0;
  int last_dlv_cyc = 0;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    logic       ovr;
  } exp_t;
  exp_t q[$];

  uart_rx_frame #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .uart_rxd  (uart_rxd),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d required <40000", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic ovr);
    exp_t e;
    e.is_ferr = 1'b0; e.data = d; e.ovr = ovr;
    q.push_back(e);
  endtask

  task automatic push_ferr();
    exp_t e;
    e.is_ferr = 1'b1; e.data = 8'h00; e.ovr = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: a new byte is visible when rx_valid rises, or stays high across an accepted ack.
  logic m_prev_valid = 1'b0;
  logic m_ack_pend   = 1'b0;
  logic m_prev_ferr  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_b) begin
      m_prev_valid = 1'b0;
      m_ack_pend   = 1'b0;
      m_prev_ferr  = 1'b0;
    end else begin
      if (rx_valid && (!m_prev_valid || m_ack_pend)) begin
        last_dlv_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("sb_kind_byte", {31'h0, e.is_ferr}, 32'd0);
          chk("sb_rx_data", {24'h0, rx_data}, {24'h0, e.data});
          chk("sb_overrun", {31'h0, overrun}, {31'h0, e.ovr});
          chk("sb_no_ferr", {31'h0, frame_err}, 32'd0);
        end
      end
      if (frame_err && m_prev_ferr)
        chk("ferr_width", 32'd2, 32'd1);
      else if (frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_ferr", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_kind_ferr", {31'h0, e.is_ferr}, 32'd1);
          chk("ferr_no_valid", {31'h0, rx_valid}, 32'd0);
        end
      end
      m_prev_valid = rx_valid;
      m_ack_pend   = rx_valid && rx_ack;
      m_prev_ferr  = frame_err;
    end
  end

  task automatic hold(input logic b, input int n);
    uart_rxd = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_k = cyc + 1;
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    hold(stop, 16);
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
    chk("ack_clears_valid", {31'h0, rx_valid}, 32'd0);
    chk("ack_clears_overrun", {31'h0, overrun}, 32'd0);
  endtask

  task automatic wait_valid_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rx_valid) begin seen = 1'b1; break; end
    end
    if (!seen) chk("wait_valid_timeout", 32'd0, 32'd1);
    else ack_pulse();
  endtask

  initial begin
    bit seen_busy;
    reset_b  = 1'b1;
    uart_rxd = 1'b1;
    rx_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b0;
    hold(1'b1, 4);

    chk("rst_rx_data", {24'h0, rx_data}, 32'h00);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'd0);
    chk("rst_overrun", {31'h0, overrun}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);

    // Single byte and latency
    push_byte(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    chk("a5_latency", last_dlv_cyc - t_k, 32'd154);
    chk("a5_valid", {31'h0, rx_valid}, 32'd1);
    ack_pulse();
    hold(1'b1, 16);

    // Back-to-back, acked
    push_byte(8'h00, 1'b0);
    push_byte(8'hFF, 1'b0);
    fork
      begin send_frame(8'h00, 1'b1); send_frame(8'hFF, 1'b1); end
      begin wait_valid_ack(); wait_valid_ack(); end
    join
    hold(1'b1, 16);

    // Start glitch
    seen_busy = 1'b0;
    uart_rxd  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) uart_rxd = 1'b1;
      @(posedge clk); #1;
      if (busy) seen_busy = 1'b1;
    end
    chk("glitch_busy_seen", {31'h0, seen_busy}, 32'd1);
    chk("glitch_busy_end", {31'h0, busy}, 32'd0);
    chk("glitch_no_valid", {31'h0, rx_valid}, 32'd0);

    // Framing error with line held low
    push_ferr();
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 40);
    chk("break_busy", {31'h0, busy}, 32'd1);
    chk("break_no_valid", {31'h0, rx_valid}, 32'd0);
    hold(1'b1, 4);
    chk("break_exit_busy", {31'h0, busy}, 32'd0);
    hold(1'b1, 16);
    push_byte(8'h12, 1'b0);
    fork
      send_frame(8'h12, 1'b1);
      wait_valid_ack();
    join
    hold(1'b1, 16);

    // Overrun, no ack
    push_byte(8'h11, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ovr_rx_data", {24'h0, rx_data}, 32'h11);
    chk("ovr_valid", {31'h0, rx_valid}, 32'd1);
    chk("ovr_flag", {31'h0, overrun}, 32'd1);
    ack_pulse();
    hold(1'b1, 16);

    // Ack on the same edge as the second delivery
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk); #1;
        while (cyc < t_k + 153) begin @(posedge clk); #1; end
        rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
      end
    join
    chk("same_edge_rx_data", {24'h0, rx_data}, 32'h22);
    chk("same_edge_valid", {31'h0, rx_valid}, 32'd1);
    chk("same_edge_overrun", {31'h0, overrun}, 32'd0);
    ack_pulse();
    hold(1'b1, 16);

    // Reset during bit 4 of 0xF0 (line high from bit 4 on)
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk); #1;
        while (cyc < t_k + 86) begin @(posedge clk); #1; end
        reset_b = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy_in_rst", {31'h0, busy}, 32'd0);
        @(posedge clk); #1 reset_b = 1'b0;
        chk("midrst_rx_data", {24'h0, rx_data}, 32'h00);
        chk("midrst_rx_valid", {31'h0, rx_valid}, 32'd0);
        chk("midrst_frame_err", {31'h0, frame_err}, 32'd0);
        chk("midrst_overrun", {31'h0, overrun}, 32'd0);
        chk("midrst_busy", {31'h0, busy}, 32'd0);
      end
    join
    hold(1'b1, 32);
    chk("midrst_no_valid", {31'h0, rx_valid}, 32'd0);
    push_byte(8'h5A, 1'b0);
    fork
      send_frame(8'h5A, 1'b1);
      wait_valid_ack();
    join
    hold(1'b1, 16);

    chk("sb_queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
